// File: rtl/cp0_if.sv
// -----------------------------------------------------------------------------
// cp0_if -- core <-> coprocessor-0 signal bundle.
//
// Purpose: groups the per-cycle decode, exception and read/write signals that
// flow between the single-cycle MIPS core (master) and CP0 (slave).
//
// Signal summary (direction seen from the slave, cp0):
//   present_pc  in  32  address of the instruction executing this cycle
//   iscop0      in   1  current instruction is COP0-class
//   iseret      in   1  ERET decoded (qualified by iscop0)
//   mtc0        in   1  MTC0 decoded (qualified by iscop0)
//   cp0_addr    in   5  CP0 register number
//   cp0_wdata   in  32  MTC0 write data
//   syscall     in   1  SYSCALL decoded
//   ri          in   1  reserved instruction decoded
//   int_req     in   1  external interrupt request (level, synchronous)
//   cp0_rdata   out 32  MFC0 read data (combinational from cp0_addr)
//   hasexp      out  1  take an exception this cycle
//   cp0_pcout   out 32  exception vector when hasexp, else EPC
//   exl         out  1  Status.EXL
//
// Handshake semantics: there is no valid/ready pair. Every input is a
// per-cycle command that is valid for exactly the cycle it is presented and
// acts at the next rising clk edge. Every output is combinational and valid
// in that same cycle; the core never stalls CP0 and CP0 never stalls the core.
// -----------------------------------------------------------------------------
interface cp0_if;
  logic [31:0] present_pc;
  logic        iscop0;
  logic        iseret;
  logic        mtc0;
  logic [4:0]  cp0_addr;
  logic [31:0] cp0_wdata;
  logic        syscall;
  logic        ri;
  logic        int_req;
  logic [31:0] cp0_rdata;
  logic        hasexp;
  logic [31:0] cp0_pcout;
  logic        exl;

  modport master (
    output present_pc, iscop0, iseret, mtc0, cp0_addr, cp0_wdata,
           syscall, ri, int_req,
    input  cp0_rdata, hasexp, cp0_pcout, exl
  );

  modport slave (
    input  present_pc, iscop0, iseret, mtc0, cp0_addr, cp0_wdata,
           syscall, ri, int_req,
    output cp0_rdata, hasexp, cp0_pcout, exl
  );
endinterface

// File: rtl/cp0.sv
// -----------------------------------------------------------------------------
// cp0 -- Coprocessor-0 for the single-cycle MIPS core.
//
// Purpose: the exception end of the next-PC path. Raises hasexp and drives
// cp0_pcout (exception vector on entry, EPC on ERET). Holds Status(12),
// Cause(13) and EPC(14), latches the external interrupt and serves MFC0/MTC0.
//
// Ports:
//   clk   in  core clock, all state updates on posedge
//   rst   in  synchronous active-high reset
//   bus   cp0_if.slave -- see cp0_if.sv for the signal list
//
// The operating mode (NORMAL / HANDLER) is the Status.EXL bit; it is held in
// mode_q and is visible on bus.exl.
// -----------------------------------------------------------------------------
module cp0 #(
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_0400,
  parameter logic [31:0] STATUS_RESET = 32'h0000_0001
) (
  input  logic  clk,
  input  logic  rst,
  cp0_if.slave  bus
);

  localparam logic [4:0] ADDR_STATUS = 5'd12;
  localparam logic [4:0] ADDR_CAUSE  = 5'd13;
  localparam logic [4:0] ADDR_EPC    = 5'd14;

  localparam logic [4:0] CODE_INT = 5'd0;
  localparam logic [4:0] CODE_SYS = 5'd8;
  localparam logic [4:0] CODE_RI  = 5'd10;

  typedef enum logic {
    MODE_NORMAL  = 1'b0,
    MODE_HANDLER = 1'b1
  } mode_e;

  // State
  mode_e       mode_q, mode_d;
  logic        ie_q, ie_d;
  logic        ip_q, ip_d;
  logic [4:0]  code_q, code_d;
  logic [31:0] epc_q, epc_d;

  // Exception decode (produced by the output process, consumed by next-state)
  logic        int_take;
  logic        hasexp;
  logic [4:0]  exc_code;
  logic        eret;
  logic        wr_en;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q <= STATUS_RESET[1] ? MODE_HANDLER : MODE_NORMAL;
      ie_q   <= STATUS_RESET[0];
      ip_q   <= 1'b0;
      code_q <= 5'd0;
      epc_q  <= 32'd0;
    end else begin
      mode_q <= mode_d;
      ie_q   <= ie_d;
      ip_q   <= ip_d;
      code_q <= code_d;
      epc_q  <= epc_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    mode_d = mode_q;
    ie_d   = ie_q;
    code_d = code_q;
    epc_d  = epc_q;
    ip_d   = ip_q;

    if (hasexp) begin
      // Exception entry overrides any ERET or MTC0 in the same cycle.
      mode_d = MODE_HANDLER;
      code_d = exc_code;
      // SYSCALL resumes after itself; ri and interrupts re-execute.
      epc_d  = (bus.syscall && !bus.ri) ? (bus.present_pc + 32'd4)
                                        : bus.present_pc;
      if (int_take) ip_d = 1'b0;
    end else if (eret) begin
      mode_d = MODE_NORMAL;
    end else if (wr_en) begin
      case (bus.cp0_addr)
        ADDR_STATUS: begin
          ie_d   = bus.cp0_wdata[0];
          mode_d = bus.cp0_wdata[1] ? MODE_HANDLER : MODE_NORMAL;
        end
        ADDR_CAUSE: ip_d  = bus.cp0_wdata[10];
        ADDR_EPC:   epc_d = bus.cp0_wdata;
        default: ;
      endcase
    end

    // A level request present at the edge always (re)latches the pending bit,
    // so a request held through the taking cycle stays pending.
    if (bus.int_req) ip_d = 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Output / decode logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // The interrupt is taken only when nothing of higher priority fires.
    int_take = ip_q && ie_q && (mode_q == MODE_NORMAL) && !bus.ri && !bus.syscall;
    hasexp   = bus.ri || bus.syscall || (ip_q && ie_q && (mode_q == MODE_NORMAL));
    exc_code = bus.ri ? CODE_RI : (bus.syscall ? CODE_SYS : CODE_INT);
    eret     = bus.iscop0 && bus.iseret;
    wr_en    = bus.iscop0 && bus.mtc0 && !hasexp;

    bus.hasexp    = hasexp;
    bus.exl       = (mode_q == MODE_HANDLER);
    bus.cp0_pcout = hasexp ? EXC_VECTOR : epc_q;

    case (bus.cp0_addr)
      ADDR_STATUS: bus.cp0_rdata = {30'd0, (mode_q == MODE_HANDLER), ie_q};
      ADDR_CAUSE:  bus.cp0_rdata = {21'd0, ip_q, 3'd0, code_q, 2'd0};
      ADDR_EPC:    bus.cp0_rdata = epc_q;
      default:     bus.cp0_rdata = 32'd0;
    endcase
  end

endmodule
